// File: rtl/id_ex_stage_reg_if.sv
// ID/EX stage bundle: decoded D-side fields in, registered E-side fields and
// hazard controls out. The master is the surrounding pipeline; the slave is the stage register.
interface id_ex_stage_reg_if #(parameter int XLEN = 32);
    logic            RegWriteD;
    logic [1:0]      ResultSrcD;
    logic            MemWriteD;
    logic            JumpD;
    logic            BranchD;
    logic [2:0]      ALUControlD;
    logic            ALUSrcD;
    logic [XLEN-1:0] RD1D;
    logic [XLEN-1:0] RD2D;
    logic [XLEN-1:0] PCD;
    logic [XLEN-1:0] ImmExtD;
    logic [XLEN-1:0] PCPlus4D;
    logic [4:0]      Rs1D;
    logic [4:0]      Rs2D;
    logic [4:0]      RdD;
    logic            ValidD;
    logic            PCSrcE;

    logic            RegWriteE;
    logic [1:0]      ResultSrcE;
    logic            MemWriteE;
    logic            JumpE;
    logic            BranchE;
    logic [2:0]      ALUControlE;
    logic            ALUSrcE;
    logic [XLEN-1:0] RD1E;
    logic [XLEN-1:0] RD2E;
    logic [XLEN-1:0] PCE;
    logic [XLEN-1:0] ImmExtE;
    logic [XLEN-1:0] PCPlus4E;
    logic [4:0]      Rs1E;
    logic [4:0]      Rs2E;
    logic [4:0]      RdE;
    logic            ValidE;

    logic            StallF;
    logic            StallD;
    logic            FlushD;
    logic            FlushE;

    modport master (
        output RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD,
               RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD, ValidD, PCSrcE,
        input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
               RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE,
               StallF, StallD, FlushD, FlushE
    );

    modport slave (
        input  RegWriteD, ResultSrcD, MemWriteD, JumpD, BranchD, ALUControlD, ALUSrcD,
               RD1D, RD2D, PCD, ImmExtD, PCPlus4D, Rs1D, Rs2D, RdD, ValidD, PCSrcE,
        output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE,
               RD1E, RD2E, PCE, ImmExtE, PCPlus4E, Rs1E, Rs2E, RdE, ValidE,
               StallF, StallD, FlushD, FlushE
    );
endinterface

// File: rtl/id_ex_stage_reg.sv
// Decode-to-Execute pipeline register with load-use stall and redirect flush generation.
// E always advances; a stall only freezes F/D upstream while E takes a bubble.
module id_ex_stage_reg #(
    parameter int XLEN = 32
) (
    input logic              clk,
    input logic              rst_n,
    id_ex_stage_reg_if.slave bus
);
    localparam logic [XLEN-1:0] ZERO_W = '0;

    logic lw_stall;
    logic flush_e;

    // A load in E whose result is needed by the real instruction in D; x0 never hazards.
    always_comb begin
        lw_stall = bus.ValidE && (bus.ResultSrcE == 2'b01) && (bus.RdE != 5'd0) &&
                   bus.ValidD && ((bus.Rs1D == bus.RdE) || (bus.Rs2D == bus.RdE));
        flush_e  = lw_stall || bus.PCSrcE;
    end

    assign bus.StallF = lw_stall;
    assign bus.StallD = lw_stall;
    assign bus.FlushD = bus.PCSrcE;
    assign bus.FlushE = flush_e;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.RegWriteE   <= 1'b0;
            bus.ResultSrcE  <= 2'b00;
            bus.MemWriteE   <= 1'b0;
            bus.JumpE       <= 1'b0;
            bus.BranchE     <= 1'b0;
            bus.ALUControlE <= 3'b000;
            bus.ALUSrcE     <= 1'b0;
            bus.RD1E        <= ZERO_W;
            bus.RD2E        <= ZERO_W;
            bus.PCE         <= ZERO_W;
            bus.ImmExtE     <= ZERO_W;
            bus.PCPlus4E    <= ZERO_W;
            bus.Rs1E        <= 5'd0;
            bus.Rs2E        <= 5'd0;
            bus.RdE         <= 5'd0;
            bus.ValidE      <= 1'b0;
        end else if (flush_e) begin
            // Data is cleared along with controls so a bubble is all zeros.
            bus.RegWriteE   <= 1'b0;
            bus.ResultSrcE  <= 2'b00;
            bus.MemWriteE   <= 1'b0;
            bus.JumpE       <= 1'b0;
            bus.BranchE     <= 1'b0;
            bus.ALUControlE <= 3'b000;
            bus.ALUSrcE     <= 1'b0;
            bus.RD1E        <= ZERO_W;
            bus.RD2E        <= ZERO_W;
            bus.PCE         <= ZERO_W;
            bus.ImmExtE     <= ZERO_W;
            bus.PCPlus4E    <= ZERO_W;
            bus.Rs1E        <= 5'd0;
            bus.Rs2E        <= 5'd0;
            bus.RdE         <= 5'd0;
            bus.ValidE      <= 1'b0;
        end else begin
            bus.RegWriteE   <= bus.RegWriteD;
            bus.ResultSrcE  <= bus.ResultSrcD;
            bus.MemWriteE   <= bus.MemWriteD;
            bus.JumpE       <= bus.JumpD;
            bus.BranchE     <= bus.BranchD;
            bus.ALUControlE <= bus.ALUControlD;
            bus.ALUSrcE     <= bus.ALUSrcD;
            bus.RD1E        <= bus.RD1D;
            bus.RD2E        <= bus.RD2D;
            bus.PCE         <= bus.PCD;
            bus.ImmExtE     <= bus.ImmExtD;
            bus.PCPlus4E    <= bus.PCPlus4D;
            bus.Rs1E        <= bus.Rs1D;
            bus.Rs2E        <= bus.Rs2D;
            bus.RdE         <= bus.RdD;
            bus.ValidE      <= bus.ValidD;
        end
    end
endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
- Decode-to-Execute pipeline register with integrated load-use stall and control-hazard flush generation.
- Captures decoded controls, operands and register indices from the ID stage and presents them as E-stage signals.
- Its outputs Rs1E, Rs2E and RdE feed the forwarding unit directly.
- Produces StallF/StallD/FlushD/FlushE for the fetch PC register and the IF/ID register.

Parameters:
- XLEN, 32, datapath width of operands, PC and immediate.

Ports:
- clk  in  1  core clock, all state rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- RegWriteD  in  1  decoded register-file write enable.
- ResultSrcD  in  2  writeback select; 01 = load data.
- MemWriteD  in  1  store enable.
- JumpD  in  1  jal/jalr.
- BranchD  in  1  conditional branch.
- ALUControlD  in  3  ALU operation.
- ALUSrcD  in  1  ALU B operand select.
- RD1D  in  XLEN  register file port 1 data.
- RD2D  in  XLEN  register file port 2 data.
- PCD  in  XLEN  instruction PC.
- ImmExtD  in  XLEN  extended immediate.
- PCPlus4D  in  XLEN  PC+4.
- Rs1D  in  5  source register 1 index.
- Rs2D  in  5  source register 2 index.
- RdD  in  5  destination index.
- ValidD  in  1  ID stage holds a real instruction.
- PCSrcE  in  1  redirect taken in E (branch taken or jump).
- RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE, ALUSrcE  out  same widths as D  registered controls.
- RD1E, RD2E, PCE, ImmExtE, PCPlus4E  out  XLEN  registered data.
- Rs1E, Rs2E, RdE  out  5  registered indices, to forwarding unit.
- ValidE  out  1  E stage holds a real instruction.
- StallF  out  1  hold PC register.
- StallD  out  1  hold IF/ID register.
- FlushD  out  1  clear IF/ID register.
- FlushE  out  1  internal bubble insert, exported for debug/perf.

Behaviour:
- Reset (rst_n low, asynchronous): every registered E output is 0, including ValidE, RdE and controls. The resulting bubble is a NOP (no RegWrite, no MemWrite, no Branch, no Jump).
- lwStall (combinational) = ValidE & (ResultSrcE == 2'b01) & (RdE != 0) & ValidD & ((Rs1D == RdE) | (Rs2D == RdE)).
- Outputs:
  - StallF = StallD = lwStall.
  - FlushD = PCSrcE.
  - FlushE = lwStall | PCSrcE.
- Register update at each rising clk (rst_n high):
  - FlushE = 1: all E fields load 0, ValidE = 0 (bubble).
  - Otherwise: all E fields load their D counterparts; ValidE = ValidD.
- The block never holds the E stage; E always advances. Stall only freezes F/D upstream.
- Latency: one cycle D-to-E. lwStall lasts exactly one cycle per load-use pair, because the bubble clears ResultSrcE on the next edge.
- Simultaneous lwStall and PCSrcE:
  - FlushE = 1, FlushD = 1, and StallF/StallD also assert.
  - The PC register gives PCSrcE redirect priority over StallF (documented upstream requirement).
  - The stalled D instruction is wrong-path and is discarded by FlushD.
- Rs1D/Rs2D match against x0: no stall (RdE != 0 guard).
- A store's Rs2D matching a load's RdE stalls. No store-data forwarding bypass exists in this design.
- Controls and data are both cleared on flush, giving deterministic zeros for verification.
- Reset deasserting mid-stream: the first edge after release captures D normally. Outputs never glitch to non-zero while rst_n is low.

Test Plan:
- Reset: drive all D inputs non-zero, assert rst_n=0 between edges → all E outputs 0 immediately (asynchronous). Release → next edge ValidE=1, RdE=RdD.
- Pass-through: RegWriteD=1, RdD=5, RD1D=0xDEADBEEF, ImmExtD=0x10, ValidD=1 → next cycle RegWriteE=1, RdE=5, RD1E=0xDEADBEEF, ImmExtE=0x10. StallF/StallD/FlushD/FlushE=0.
- Load-use: E holds lw x7 (ResultSrcE=01, RdE=7, ValidE=1); D holds add x8,x7,x1 (Rs1D=7) → StallF=StallD=FlushE=1 for exactly one cycle. Next cycle ValidE=0, RegWriteE=0. The following cycle RdE=8 and no stall.
- x0 / non-load: lw with RdE=0 and Rs1D=0 → no stall. An ALU op in E with RdE=Rs1D=3 and ResultSrcE=00 → no stall (forwarding path).
- Branch flush: PCSrcE=1 with a valid instruction in D → FlushD=1, FlushE=1. Next cycle all E outputs 0, ValidE=0.
- Simultaneous: load-use condition and PCSrcE=1 in the same cycle → StallF=StallD=FlushD=FlushE=1. Next cycle E is a bubble; the cycle after shows no residual stall.
